// File: rtl/serial_magnitude_comparator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_magnitude_comparator_if                                           |
// | Start/done handshake, operands and result flags of the comparator.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface serial_magnitude_comparator_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             gt;
   logic             eq;
   logic             lt;

   modport master (
      output start, a, b,
      input  busy, done, gt, eq, lt
   );

   modport slave (
      input  start, a, b,
      output busy, done, gt, eq, lt
   );
endinterface
`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_magnitude_comparator                                              |
// | MSB-chunk-first sequential compare with early exit; build macro          |
// | SIGNED_CMP_EN treats operands as two's complement.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_magnitude_comparator #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   serial_magnitude_comparator_if.slave cmp
);
   localparam int c_NCHUNK = WIDTH / CHUNK;
   localparam int c_IDX_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NCHUNK - 1);

   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_RUN  = 1'b1;

   logic [0:0]         r_state;
   logic [0:0]         w_state_nxt;
   logic [WIDTH-1:0]   r_sh_a;
   logic [WIDTH-1:0]   r_sh_b;
   logic [c_IDX_W-1:0] r_idx;
   logic               r_done;
   logic               r_gt;
   logic               r_eq;
   logic               r_lt;

   logic [CHUNK-1:0]   w_ca;
   logic [CHUNK-1:0]   w_cb;
   logic               w_chunk_gt;
   logic               w_chunk_lt;
   logic               w_last;
   logic               w_accept;

   assign w_ca     = r_sh_a[WIDTH-1 -: CHUNK];
   assign w_cb     = r_sh_b[WIDTH-1 -: CHUNK];
   assign w_last   = (r_idx == c_LAST);
   assign w_accept = (r_state == c_ST_IDLE) && cmp.start;

   // The sign bit only ever lives in chunk 0, so only that chunk is signed.
   always_comb begin
      w_chunk_gt = 1'b0;
      w_chunk_lt = 1'b0;
`ifdef SIGNED_CMP_EN
      if (r_idx == '0) begin
         w_chunk_gt = $signed(w_ca) > $signed(w_cb);
         w_chunk_lt = $signed(w_ca) < $signed(w_cb);
      end else begin
         w_chunk_gt = w_ca > w_cb;
         w_chunk_lt = w_ca < w_cb;
      end
`else
      w_chunk_gt = w_ca > w_cb;
      w_chunk_lt = w_ca < w_cb;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: if (cmp.start) w_state_nxt = c_ST_RUN;
         c_ST_RUN:  if (w_chunk_gt || w_chunk_lt || w_last) w_state_nxt = c_ST_IDLE;
         default:   w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_a <= '0;
         r_sh_b <= '0;
         r_idx  <= '0;
         r_done <= 1'b0;
         r_gt   <= 1'b0;
         r_eq   <= 1'b0;
         r_lt   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_sh_a <= cmp.a;
            r_sh_b <= cmp.b;
            r_idx  <= '0;
            r_gt   <= 1'b0;
            r_eq   <= 1'b0;
            r_lt   <= 1'b0;
         end else if (r_state == c_ST_RUN) begin
            if (w_chunk_gt || w_chunk_lt) begin
               r_gt   <= w_chunk_gt;
               r_lt   <= w_chunk_lt;
               r_done <= 1'b1;
            end else if (w_last) begin
               r_eq   <= 1'b1;
               r_done <= 1'b1;
            end else begin
               r_sh_a <= r_sh_a << CHUNK;
               r_sh_b <= r_sh_b << CHUNK;
               r_idx  <= r_idx + c_IDX_W'(1);
            end
         end
      end
   end

   always_comb begin
      cmp.busy = (r_state == c_ST_RUN);
      cmp.done = r_done;
      cmp.gt   = r_gt;
      cmp.eq   = r_eq;
      cmp.lt   = r_lt;
   end
endmodule
`default_nettype wire

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Multi-cycle magnitude comparator for two WIDTH-bit operands. It processes CHUNK bits per clock, most-significant chunk first, and stops early at the first chunk that differs. It reports greater / equal / less as mutually exclusive flags through a start/done handshake. It is the parametrised, sequential successor to the fixed two-bit combinational comparator, for datapaths where a full-width single-cycle compare is too costly.

## Interface
- WIDTH, default 8: operand width in bits; must be an integer multiple of CHUNK and ≥ CHUNK.
- CHUNK, default 2: bits compared per clock cycle; NCHUNK = WIDTH/CHUNK.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; a and b are sampled on the same edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse when the result flags update.
- gt  output  1  A > B (held until the next accepted start).
- eq  output  1  A == B (held).
- lt  output  1  A < B (held).

## Operation
- Reset values:
  - All outputs are 0: busy, done, gt, eq, lt.
  - State is IDLE and internal registers are cleared.
- States:
  - IDLE to RUN when start = 1 on an edge.
    - On that edge, a and b are latched into internal shift registers.
    - Chunk index is set to 0 and busy is set to 1.
    - gt/eq/lt are cleared to 0.
  - RUN evaluates on each edge:
    - The top CHUNK bits of each shift register are compared (chunk k = bits WIDTH-1-k·CHUNK down to WIDTH-(k+1)·CHUNK).
    - If the chunks differ, gt or lt is set, done = 1, busy = 0, and the state goes to IDLE.
    - If the chunks are equal and k = NCHUNK-1, eq = 1, done = 1, busy = 0, and the state goes to IDLE.
    - Otherwise, both registers shift left by CHUNK and k increments.
- done is high for exactly one cycle.
- gt/eq/lt stay stable until the next accepted start, which clears them.
- Exactly one of gt/eq/lt is 1 after any completed comparison. All three are 0 after reset and during RUN.
- start while busy = 1 is ignored; operands are not resampled.
- start in the same cycle that done is high is accepted, because the state is already IDLE.
- a and b are don't-care except on the accepting edge.
- Reset asserted mid-RUN immediately aborts:
  - All outputs go to 0.
  - No done pulse is produced.
- Chunk comparison is unsigned, except the top chunk under the configuration macro below.

## Timing
- The accepting edge is E0. done, result flags and busy = 0 become visible after edge E0+n:
  - n = index of the first differing chunk + 1.
  - n = NCHUNK when the operands are equal.
- Minimum latency is 1 cycle; maximum is NCHUNK cycles.
- busy is high from after E0 until after E0+n.
- Back-to-back throughput: a new start may be accepted on edge E0+n+1 (the done cycle).
- No combinational path from any input to any output.

## Configuration
- SIGNED_CMP_EN:
  - When defined, operands are two's-complement.
  - Chunk 0 (containing the sign bit) is compared as a signed CHUNK-bit value; remaining chunks are compared unsigned.
  - Early termination applies unchanged.
- Without the macro, all chunks are compared unsigned.
- Latency and handshake are identical in both builds.

## Test plan
WIDTH=8, CHUNK=2 unless noted.
- Reset, then idle 3 cycles -> busy = done = gt = eq = lt = 0 throughout.
- start with a=0xB4, b=0x74 -> gt=1, done pulse 1 cycle after acceptance; a=0x12, b=0x13 -> lt=1 after 4 cycles; a=0x5A, b=0x5A -> eq=1 after 4 cycles, flags held until the next start.
- a=0x80, b=0x01 -> unsigned build gt=1; SIGNED_CMP_EN build lt=1; both after 1 cycle.
- start a=0x12, b=0x13, then pulse start with a=0xFF, b=0x00 on cycle 2 -> ignored, result lt after 4 cycles; start asserted during the done cycle with a=0x40, b=0x40 -> accepted, eq after 4 more cycles.
- rst_n driven low on cycle 2 of an a=0x5A, b=0x5A run -> all outputs 0 immediately, no done pulse, next start behaves normally.
- WIDTH=16, CHUNK=4, a=0x1234, b=0x1235 -> lt after 4 cycles; a=0xF000, b=0x0FFF -> gt after 1 cycle.
